// File: rtl/gpp_if.sv
// Packet word stream between ingress filter stages: word strobe, 134-bit word,
// end-of-packet valid flag with its strobe, and almost-full back-pressure.
interface gpp_if;
  logic         wr;
  logic [133:0] data;
  logic         valid;
  logic         valid_wr;
  logic         alf;

  modport master (output wr, data, valid, valid_wr, input alf);
  modport slave  (input wr, data, valid, valid_wr, output alf);
endinterface

// File: rtl/gpp_ingress_filter.sv
// Store-and-forward packet filter: buffers whole packets, then forwards or
// discards each one based on its length, its valid flag and a well-formed tail.
//
// write state | meaning
// SYNC        | discarding words until a head word is seen
// ACCEPT      | storing every word, counting words per packet
//
// read state  | meaning
// IDLE        | waiting for a keep flag (outputs held at 0)
// SEND        | forwarding one stored word per cycle up to the tail
// DROP        | popping one stored word per cycle up to the tail, nothing driven
module gpp_ingress_filter #(
  parameter int MAX_WORDS = 96,
  parameter int ALF_TH    = 160
) (
  input  logic        clk,
  input  logic        rst,
  gpp_if.slave        in_data_if,
  gpp_if.master       out_data_if,
  output logic [31:0] pass_cnt,
  output logic [31:0] drop_cnt,
  output logic [31:0] ipv4_cnt,
  output logic        ovf_err
);

  localparam int CW = $clog2(MAX_WORDS + 2);

  localparam logic [0:0] W_SYNC   = 1'b0;
  localparam logic [0:0] W_ACCEPT = 1'b1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_SEND = 2'd1;
  localparam logic [1:0] R_DROP = 2'd2;

  logic [133:0] mem_q [256];
  logic [7:0]   wr_ptr_q, rd_ptr_q;
  logic [8:0]   occ_q;

  logic         kmem_q [64];
  logic [5:0]   kwr_ptr_q, krd_ptr_q;
  logic [6:0]   kocc_q;

  logic [0:0]   wst_q, wst_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]   rst_q, rst_d;
  logic [7:0]   widx_q, widx_d;

  logic         out_wr_q, out_wr_d;
  logic [133:0] out_data_q, out_data_d;
  logic         out_v_q, out_v_d;
  logic         out_vwr_q, out_vwr_d;
  logic [31:0]  pass_q, drop_q, ipv4_q;
  logic         ovf_q;

  logic store, head, data_full, wr_en, wr_ovf;
  logic flag_push, keep, kfull, kpush_en, kovf;
  logic kempty, kflag, dempty, rd_tail, rd_en, kpop;
  logic pass_inc, drop_inc, ipv4_inc;
  logic [133:0] rd_word;

  // Write side
  always_comb begin
    head      = in_data_if.data[133:132] == 2'b01;
    store     = in_data_if.wr && (wst_q == W_ACCEPT || head);
    data_full = occ_q == 9'd256;
    wr_en     = store && (!data_full || rd_en);
    wr_ovf    = store && data_full && !rd_en;

    cnt_inc = (store && cnt_q != CW'(MAX_WORDS + 1)) ? cnt_q + CW'(1) : cnt_q;

    flag_push = in_data_if.valid_wr && wst_q == W_ACCEPT;
    keep      = in_data_if.valid && in_data_if.wr && cnt_inc <= CW'(MAX_WORDS)
                && in_data_if.data[133:132] == 2'b10;
    kfull     = kocc_q == 7'd64;
    kpush_en  = flag_push && (!kfull || kpop);
    kovf      = flag_push && kfull && !kpop;

    cnt_d = flag_push ? '0 : cnt_inc;
    wst_d = (wst_q == W_SYNC && in_data_if.wr && head) ? W_ACCEPT : wst_q;
  end

  // Read side
  always_comb begin
    kempty  = kocc_q == 7'd0;
    kflag   = kmem_q[krd_ptr_q];
    dempty  = occ_q == 9'd0;
    rd_word = mem_q[rd_ptr_q];
    rd_tail = rd_word[133:132] == 2'b10;

    rst_d      = rst_q;
    widx_d     = widx_q;
    kpop       = 1'b0;
    rd_en      = 1'b0;
    out_wr_d   = 1'b0;
    out_data_d = '0;
    out_v_d    = 1'b0;
    out_vwr_d  = 1'b0;
    pass_inc   = 1'b0;
    drop_inc   = 1'b0;
    ipv4_inc   = 1'b0;

    case (rst_q)
      R_IDLE: begin
        widx_d = '0;
        if (!kempty) begin
          if (!kflag) begin
            kpop  = 1'b1;
            rst_d = R_DROP;
          end else if (!out_data_if.alf) begin
            kpop  = 1'b1;
            rst_d = R_SEND;
          end
        end
      end
      R_SEND: begin
        if (!dempty) begin
          rd_en      = 1'b1;
          out_wr_d   = 1'b1;
          out_data_d = rd_word;
          ipv4_inc   = widx_q == 8'd2 && rd_word[31:16] == 16'h0800;
          if (widx_q != 8'hFF) widx_d = widx_q + 8'd1;
          if (rd_tail) begin
            out_v_d   = 1'b1;
            out_vwr_d = 1'b1;
            pass_inc  = 1'b1;
            rst_d     = R_IDLE;
          end
        end
      end
      R_DROP: begin
        if (!dempty) begin
          rd_en = 1'b1;
          if (rd_tail) begin
            drop_inc = 1'b1;
            rst_d    = R_IDLE;
          end
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  // Buffer storage carries no reset; occupancy and pointers define its contents
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= in_data_if.data;
    if (!rst && kpush_en) kmem_q[kwr_ptr_q] <= keep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      kwr_ptr_q  <= '0;
      krd_ptr_q  <= '0;
      kocc_q     <= '0;
      wst_q      <= W_SYNC;
      cnt_q      <= '0;
      rst_q      <= R_IDLE;
      widx_q     <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_v_q    <= 1'b0;
      out_vwr_q  <= 1'b0;
      pass_q     <= '0;
      drop_q     <= '0;
      ipv4_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 8'd1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 8'd1;
      case ({wr_en, rd_en})
        2'b10:   occ_q <= occ_q + 9'd1;
        2'b01:   occ_q <= occ_q - 9'd1;
        default: occ_q <= occ_q;
      endcase
      if (kpush_en) kwr_ptr_q <= kwr_ptr_q + 6'd1;
      if (kpop)     krd_ptr_q <= krd_ptr_q + 6'd1;
      case ({kpush_en, kpop})
        2'b10:   kocc_q <= kocc_q + 7'd1;
        2'b01:   kocc_q <= kocc_q - 7'd1;
        default: kocc_q <= kocc_q;
      endcase
      wst_q      <= wst_d;
      cnt_q      <= cnt_d;
      rst_q      <= rst_d;
      widx_q     <= widx_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
      out_v_q    <= out_v_d;
      out_vwr_q  <= out_vwr_d;
      if (pass_inc) pass_q <= pass_q + 32'd1;
      if (drop_inc) drop_q <= drop_q + 32'd1;
      if (ipv4_inc) ipv4_q <= ipv4_q + 32'd1;
      ovf_q      <= ovf_q | wr_ovf | kovf;
    end
  end

  assign in_data_if.alf       = occ_q >= 9'(ALF_TH);
  assign out_data_if.wr       = out_wr_q;
  assign out_data_if.data     = out_data_q;
  assign out_data_if.valid    = out_v_q;
  assign out_data_if.valid_wr = out_vwr_q;
  assign pass_cnt = pass_q;
  assign drop_cnt = drop_q;
  assign ipv4_cnt = ipv4_q;
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_gpp_ingress_filter.sv
// Randomized and directed bench for gpp_ingress_filter against a packet-level
// reference model (expected word queue plus expected counters).
module tb_gpp_ingress_filter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpp_if in_if ();
  gpp_if out_if ();

  logic [31:0] pass_cnt, drop_cnt, ipv4_cnt;
  logic        ovf_err;

  gpp_ingress_filter #(.MAX_WORDS(96), .ALF_TH(160)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data_if (in_if.slave),
    .out_data_if(out_if.master),
    .pass_cnt   (pass_cnt),
    .drop_cnt   (drop_cnt),
    .ipv4_cnt   (ipv4_cnt),
    .ovf_err    (ovf_err)
  );

  typedef struct {
    logic [133:0] d;
    bit           last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   exp_pass, exp_drop, exp_ipv4;
  bit   alf_chk_en = 1'b0;
  int   occ_model;
  bit   prev_vwr = 1'b0;
  int   alf_mode = 0;

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Downstream almost-full: 0 = released, 1 = held, 2 = random per cycle
  always begin
    @(posedge clk);
    #2;
    if (alf_mode == 2) out_if.alf = 1'($urandom_range(0, 1));
    else               out_if.alf = (alf_mode == 1);
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && out_if.wr === 1'b1) begin
      chk("gap_after_tail", {133'b0, prev_vwr}, 134'd0);
      if (exp_q.size() == 0) begin
        chk("extra_word", 134'd1, 134'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_if.data, mon_e.d);
        chk("out_valid_wr", {133'b0, out_if.valid_wr}, {133'b0, mon_e.last});
        chk("out_valid", {133'b0, out_if.valid}, {133'b0, mon_e.last});
      end
    end
    prev_vwr = (out_if.valid_wr === 1'b1);
  end

  function automatic logic [133:0] mk_word(input int idx, input int len, input bit ipv4);
    logic [133:0] w;
    w[31:0]    = $urandom;
    w[63:32]   = $urandom;
    w[95:64]   = $urandom;
    w[127:96]  = $urandom;
    w[131:128] = 4'($urandom);
    if (idx == 0)            w[133:132] = 2'b01;
    else if (idx == len - 1) w[133:132] = 2'b10;
    else                     w[133:132] = 2'b11;
    if (idx == 2) begin
      if (ipv4) w[31:16] = 16'h0800;
      else if (w[31:16] == 16'h0800) w[16] = 1'b1;
    end
    return w;
  endfunction

  task automatic send_word(input logic [133:0] d, input bit vwr, input bit v);
    in_if.wr       = 1'b1;
    in_if.data     = d;
    in_if.valid_wr = vwr;
    in_if.valid    = v;
    @(posedge clk);
    #1;
    in_if.wr       = 1'b0;
    in_if.valid_wr = 1'b0;
    in_if.valid    = 1'b0;
    in_if.data     = '0;
    if (alf_chk_en) begin
      occ_model++;
      chk("in_alf_level", {133'b0, in_if.alf}, {133'b0, (occ_model >= 160)});
    end
  endtask

  task automatic send_pkt(input int len, input bit v, input bit ipv4);
    logic [133:0] w;
    bit keep;
    exp_t e;
    keep = v && (len <= 96);
    for (int i = 0; i < len; i++) begin
      w = mk_word(i, len, ipv4);
      if (keep) begin
        e.d = w;
        e.last = (i == len - 1);
        exp_q.push_back(e);
      end
      send_word(w, i == len - 1, (i == len - 1) ? v : 1'b0);
    end
    if (keep) begin
      exp_pass++;
      if (ipv4 && len >= 3) exp_ipv4++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((pass_cnt !== 32'(exp_pass) || drop_cnt !== 32'(exp_drop)) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_pass_cnt"}, 134'(pass_cnt), 134'(exp_pass));
    chk({tag, "_drop_cnt"}, 134'(drop_cnt), 134'(exp_drop));
    chk({tag, "_ipv4_cnt"}, 134'(ipv4_cnt), 134'(exp_ipv4));
    chk({tag, "_missing_words"}, 134'(exp_q.size()), 134'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_pass = 0;
    exp_drop = 0;
    exp_ipv4 = 0;
    prev_vwr = 1'b0;
  endtask

  initial begin
    int n;
    logic [133:0] w;
    rst            = 1'b1;
    in_if.wr       = 1'b0;
    in_if.data     = '0;
    in_if.valid    = 1'b0;
    in_if.valid_wr = 1'b0;
    alf_mode       = 0;
    do_reset();

    chk("rst_out_wr", {133'b0, out_if.wr}, 134'd0);
    chk("rst_in_alf", {133'b0, in_if.alf}, 134'd0);
    chk("rst_pass", 134'(pass_cnt), 134'd0);
    chk("rst_drop", 134'(drop_cnt), 134'd0);
    chk("rst_ipv4", 134'(ipv4_cnt), 134'd0);
    chk("rst_ovf", {133'b0, ovf_err}, 134'd0);

    // Single 4-word good packet, with first-word latency
    send_pkt(4, 1'b1, 1'b0);
    n = 0;
    while (out_if.wr !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_word_latency", {133'b0, (n <= 3)}, 134'd1);
    drain("pass4");

    do_reset();
    send_pkt(4, 1'b0, 1'b0);
    drain("drop4");
    send_pkt(5, 1'b1, 1'b0);
    drain("after_drop");

    // Length boundary
    do_reset();
    send_pkt(97, 1'b1, 1'b0);
    send_pkt(96, 1'b1, 1'b0);
    drain("len_boundary");

    // Back-pressure: nothing leaves while downstream is almost full
    do_reset();
    alf_mode = 1;
    alf_chk_en = 1'b1;
    occ_model = 0;
    for (int p = 0; p < 10; p++) send_pkt(16, 1'b1, 1'(p % 2));
    alf_chk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("held_no_output", 134'(pass_cnt), 134'd0);
    alf_mode = 0;
    drain("backpressure");

    // Reset in the middle of a packet
    do_reset();
    send_word(mk_word(0, 5, 1'b0), 1'b0, 1'b0);
    send_word(mk_word(1, 5, 1'b0), 1'b0, 1'b0);
    do_reset();
    send_word(mk_word(2, 5, 1'b0), 1'b0, 1'b0);
    send_word(mk_word(3, 5, 1'b0), 1'b0, 1'b0);
    send_word(mk_word(4, 5, 1'b0), 1'b1, 1'b1);
    send_pkt(5, 1'b1, 1'b0);
    drain("mid_reset");

    // IPv4 ethertype detection only on passed packets
    do_reset();
    send_pkt(6, 1'b1, 1'b1);
    send_pkt(6, 1'b1, 1'b0);
    send_pkt(6, 1'b0, 1'b1);
    drain("ipv4");

    // Random traffic with random downstream back-pressure
    do_reset();
    alf_mode = 2;
    for (int p = 0; p < 40; p++) begin
      n = 0;
      while (in_if.alf === 1'b1 && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 2000) chk("upstream_wait_timeout", 134'd1, 134'd0);
      if ($urandom_range(0, 9) == 0)
        send_pkt(int'($urandom_range(95, 98)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      else
        send_pkt(int'($urandom_range(3, 24)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    alf_mode = 0;
    drain("random");

    // Data buffer overflow
    do_reset();
    alf_mode = 1;
    send_word(mk_word(0, 300, 1'b0), 1'b0, 1'b0);
    for (int i = 1; i < 256; i++) send_word(mk_word(i, 300, 1'b0), 1'b0, 1'b0);
    chk("ovf_at_256", {133'b0, ovf_err}, 134'd0);
    chk("alf_when_full", {133'b0, in_if.alf}, 134'd1);
    w = mk_word(256, 300, 1'b0);
    send_word(w, 1'b0, 1'b0);
    chk("ovf_at_257", {133'b0, ovf_err}, 134'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", {133'b0, ovf_err}, 134'd1);
    alf_mode = 0;
    do_reset();
    chk("ovf_cleared", {133'b0, ovf_err}, 134'd0);
    chk("alf_cleared", {133'b0, in_if.alf}, 134'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
